// File: rtl/fp_pkg.sv
// Shared widths, flag indices and pipeline record types for the FP adder alignment front end.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 4;

    localparam int FL_NAN  = 3;
    localparam int FL_INF  = 2;
    localparam int FL_ZERO = 1;
    localparam int FL_SUBN = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic [3:0]       flags;
    } operand_t;

    // Stage-1 record: operands already ordered by magnitude, B sign already folded with sub.
    typedef struct packed {
        logic                   sign_a;
        logic                   sign_b;
        logic                   sign_l;
        logic                   eff_sub;
        logic [EXP_W-1:0]       e_l;
        logic [EXP_W-1:0]       diff;
        logic [SIG_W-1:0]       sig_l;
        logic [SIG_W-1:0]       sig_s;
        logic [FL_NAN:FL_ZERO]  flags_a;
        logic [FL_NAN:FL_ZERO]  flags_b;
    } align_s1_t;

    typedef struct packed {
        logic             res_sign;
        logic             eff_sub;
        logic [EXP_W-1:0] res_e;
        logic [SIG_W-1:0] sig_l;
        logic [SIG_W-1:0] sig_s;
        logic             spec_nan;
        logic             spec_inf;
        logic             spec_zero;
    } align_res_t;

    // Subnormals share the exponent of the smallest normal.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    function automatic logic [SIG_W-1:0] make_sig(input logic [EXP_W-1:0] e,
                                                  input logic [MAN_W-1:0] m);
        return {(e != '0), m, 3'b000};
    endfunction

endpackage

// File: rtl/fp_shift_sticky.sv
// Right shift of a significand by an exponent difference, folding every bit shifted out into bit 0.
module fp_shift_sticky #(
    parameter int SIG_W = 27,
    parameter int EXP_W = 8
) (
    input  logic [SIG_W-1:0] sig_in,
    input  logic [EXP_W-1:0] shamt,
    output logic [SIG_W-1:0] sig_out
);

    logic [SIG_W-1:0] lost_mask;
    logic             sticky;

    always_comb begin
        lost_mask = ~({SIG_W{1'b1}} << shamt);
        sticky    = |(sig_in & lost_mask);
        if (32'(shamt) >= SIG_W) begin
            sig_out = {{(SIG_W-1){1'b0}}, |sig_in};
        end else begin
            sig_out = (sig_in >> shamt) | {{(SIG_W-1){1'b0}}, sticky};
        end
    end

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage operand alignment for the FP adder: order by magnitude, align the smaller significand,
// and classify NaN/Inf/Zero results. Valid/ready on both sides with bubble-collapsing enables.
module fp_align_stage
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             a_sign,
    input  logic [EXP_W-1:0] a_e,
    input  logic [MAN_W-1:0] a_m,
    input  logic [3:0]       a_flags,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] b_e,
    input  logic [MAN_W-1:0] b_m,
    input  logic [3:0]       b_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_sign,
    output logic             eff_sub,
    output logic [EXP_W-1:0] res_e,
    output logic [SIG_W-1:0] sig_l,
    output logic [SIG_W-1:0] sig_s,
    output logic             spec_nan,
    output logic             spec_inf,
    output logic             spec_zero
);

    logic       v1_q, v1_d, v2_q, v2_d;
    logic       en1, en2;
    align_s1_t  s1_q, s1_d;
    align_res_t s2_q, s2_d;

    operand_t         op_a, op_b;
    logic             swap;
    logic [EXP_W-1:0] e_l_raw, e_s_raw;
    logic [MAN_W-1:0] m_l, m_s;

    logic [SIG_W-1:0] sig_s_sh;
    logic             nan_c, inf_c, zero_c;
    logic             unused_subn;

    assign en2       = !v2_q || out_ready;
    assign en1       = !v1_q || en2;
    assign in_ready  = en1;
    assign out_valid = v2_q;

    // The subnormal flag is implied by e == 0, which is what the datapath keys on.
    assign unused_subn = op_a.flags[FL_SUBN] ^ op_b.flags[FL_SUBN];

    always_comb begin
        op_a = '{sign: a_sign,       e: a_e, m: a_m, flags: a_flags};
        op_b = '{sign: b_sign ^ sub, e: b_e, m: b_m, flags: b_flags};
        // A wins ties so equal magnitudes keep A's sign on cancellation.
        swap    = {eff_exp(op_b.e), (op_b.e != '0), op_b.m} > {eff_exp(op_a.e), (op_a.e != '0), op_a.m};
        e_l_raw = swap ? op_b.e : op_a.e;
        e_s_raw = swap ? op_a.e : op_b.e;
        m_l     = swap ? op_b.m : op_a.m;
        m_s     = swap ? op_a.m : op_b.m;
    end

    always_comb begin
        // NOTE: every comb output gets its hold value first, so no path through the
        // if leaves a signal unassigned and no latch is inferred.
        v1_d = v1_q;
        s1_d = s1_q;
        if (en1) begin
            v1_d          = in_valid;
            s1_d.sign_a   = op_a.sign;
            s1_d.sign_b   = op_b.sign;
            s1_d.sign_l   = swap ? op_b.sign : op_a.sign;
            s1_d.eff_sub  = op_a.sign ^ op_b.sign;
            s1_d.e_l      = eff_exp(e_l_raw);
            s1_d.diff     = eff_exp(e_l_raw) - eff_exp(e_s_raw);
            s1_d.sig_l    = make_sig(e_l_raw, m_l);
            s1_d.sig_s    = make_sig(e_s_raw, m_s);
            s1_d.flags_a  = op_a.flags[FL_NAN:FL_ZERO];
            s1_d.flags_b  = op_b.flags[FL_NAN:FL_ZERO];
        end
    end

    fp_shift_sticky #(
        .SIG_W (SIG_W),
        .EXP_W (EXP_W)
    ) u_shift (
        .sig_in  (s1_q.sig_s),
        .shamt   (s1_q.diff),
        .sig_out (sig_s_sh)
    );

    always_comb begin
        nan_c  = s1_q.flags_a[FL_NAN] || s1_q.flags_b[FL_NAN]
              || (s1_q.flags_a[FL_INF] && s1_q.flags_b[FL_INF] && s1_q.eff_sub);
        inf_c  = !nan_c && (s1_q.flags_a[FL_INF] || s1_q.flags_b[FL_INF]);
        zero_c = !nan_c && !inf_c && s1_q.flags_a[FL_ZERO] && s1_q.flags_b[FL_ZERO];

        v2_d = v2_q;
        s2_d = s2_q;
        if (en2) begin
            v2_d = v1_q;
            if (nan_c) begin
                s2_d.res_sign = 1'b0;
            end else if (inf_c) begin
                s2_d.res_sign = s1_q.flags_a[FL_INF] ? s1_q.sign_a : s1_q.sign_b;
            end else if (zero_c) begin
                s2_d.res_sign = s1_q.sign_a & s1_q.sign_b;
            end else begin
                s2_d.res_sign = s1_q.sign_l;
            end
            s2_d.eff_sub   = s1_q.eff_sub;
            s2_d.res_e     = s1_q.e_l;
            s2_d.sig_l     = s1_q.sig_l;
            s2_d.sig_s     = sig_s_sh;
            s2_d.spec_nan  = nan_c;
            s2_d.spec_inf  = inf_c;
            s2_d.spec_zero = zero_c;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign res_sign  = s2_q.res_sign;
    assign eff_sub   = s2_q.eff_sub;
    assign res_e     = s2_q.res_e;
    assign sig_l     = s2_q.sig_l;
    assign sig_s     = s2_q.sig_s;
    assign spec_nan  = s2_q.spec_nan;
    assign spec_inf  = s2_q.spec_inf;
    assign spec_zero = s2_q.spec_zero;

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: expected results are queued at input handshake and
// compared in order at output handshake.
module tb_fp_align_stage;
    import fp_pkg::*;

    localparam int RES_W = 5 + EXP_W + 2 * SIG_W;
    typedef logic [RES_W-1:0] res_vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, sub;
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_m, b_m;
    logic [3:0]       a_flags, b_flags;
    logic             out_valid, out_ready;
    logic             res_sign, eff_sub;
    logic [EXP_W-1:0] res_e;
    logic [SIG_W-1:0] sig_l, sig_s;
    logic             spec_nan, spec_inf, spec_zero;

    int       n_chk  = 0;
    int       n_fail = 0;
    int       n_out  = 0;
    res_vec_t sb[$];
    res_vec_t cur_exp;
    logic     acc_last;

    fp_align_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
        .a_sign(a_sign), .a_e(a_e), .a_m(a_m), .a_flags(a_flags),
        .b_sign(b_sign), .b_e(b_e), .b_m(b_m), .b_flags(b_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_sign(res_sign), .eff_sub(eff_sub), .res_e(res_e), .sig_l(sig_l), .sig_s(sig_s),
        .spec_nan(spec_nan), .spec_inf(spec_inf), .spec_zero(spec_zero)
    );

    always #5 clk = ~clk;

    function automatic res_vec_t obs();
        return {res_sign, eff_sub, res_e, sig_l, sig_s, spec_nan, spec_inf, spec_zero};
    endfunction

    function automatic res_vec_t mk(input logic rs, input logic es, input logic [EXP_W-1:0] e,
                                    input logic [SIG_W-1:0] sl, input logic [SIG_W-1:0] ss,
                                    input logic n, input logic i, input logic z);
        return {rs, es, e, sl, ss, n, i, z};
    endfunction

    function automatic logic [3:0] flags_of(input logic [31:0] w);
        logic e_max, e_min, m_nz;
        e_max = (w[30:23] == 8'hFF);
        e_min = (w[30:23] == 8'h00);
        m_nz  = (w[22:0] != '0);
        return {e_max && m_nz, e_max && !m_nz, e_min && !m_nz, e_min && m_nz};
    endfunction

    // Reference model written from the behavioural description, bit-serial shifter.
    function automatic res_vec_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic             bse, b_big, n, i, z, rs, st;
        logic [3:0]       af, bf;
        logic [EXP_W-1:0] ea, eb, el, es, d;
        logic [SIG_W-1:0] sga, sgb, sgl, sgs, sh;
        bse = b[31] ^ s;
        af  = flags_of(a);
        bf  = flags_of(b);
        ea  = (a[30:23] == '0) ? 8'd1 : a[30:23];
        eb  = (b[30:23] == '0) ? 8'd1 : b[30:23];
        sga = {(a[30:23] != '0), a[22:0], 3'b000};
        sgb = {(b[30:23] != '0), b[22:0], 3'b000};
        b_big = {eb, sgb} > {ea, sga};
        el  = b_big ? eb : ea;
        es  = b_big ? ea : eb;
        sgl = b_big ? sgb : sga;
        sgs = b_big ? sga : sgb;
        d   = el - es;
        sh  = '0;
        st  = 1'b0;
        for (int k = 0; k < SIG_W; k++) begin
            if (k < int'(d)) st = st | sgs[k];
            else             sh[k - int'(d)] = sgs[k];
        end
        sh[0] = sh[0] | st;
        n  = af[3] || bf[3] || (af[2] && bf[2] && (a[31] ^ bse));
        i  = !n && (af[2] || bf[2]);
        z  = !n && !i && af[1] && bf[1];
        rs = n ? 1'b0 : i ? (af[2] ? a[31] : bse) : z ? (a[31] & bse) : (b_big ? bse : a[31]);
        return mk(rs, a[31] ^ bse, el, sgl, sh, n, i, z);
    endfunction

    task automatic check(input string tag, input res_vec_t o, input res_vec_t e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // One clock: outputs and handshakes sampled on the falling edge, inputs change 1 after rising edge.
    task automatic step();
        res_vec_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_chk++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_output: observed result %h expected none pending", obs());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("result_%0d", n_out), obs(), e);
            end
            n_out++;
        end
        acc_last = in_valid && in_ready;
        if (acc_last) sb.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b, input logic s);
        sub     = s;
        a_sign  = a[31]; a_e = a[30:23]; a_m = a[22:0]; a_flags = flags_of(a);
        b_sign  = b[31]; b_e = b[30:23]; b_m = b[22:0]; b_flags = flags_of(b);
        cur_exp = model(a, b, s);
    endtask

    task automatic send();
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            if (acc_last) return;
        end
        check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int c = 0; c < 30 && sb.size() != 0; c++) step();
        check("drain_empty", res_vec_t'(sb.size()), '0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        load(32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", res_vec_t'(out_valid), '0);
        check("reset_in_ready", res_vec_t'(in_ready), 1);
        check("reset_outputs", obs(), '0);

        // 1.0 + 1.0, with exact latency observation
        out_ready = 1'b1;
        load(32'h3F800000, 32'h3F800000, 1'b0);
        cur_exp = mk(0, 0, 127, 27'h4000000, 27'h4000000, 0, 0, 0);
        send();
        in_valid = 1'b0;
        check("latency_c1", res_vec_t'(out_valid), '0);
        step();
        check("latency_c2", res_vec_t'(out_valid), 1);
        step();

        // Directed values, back to back
        load(32'h3F800000, 32'hC0400000, 1'b0);
        cur_exp = mk(1, 1, 128, 27'h6000000, 27'h2000000, 0, 0, 0);
        send();
        load(32'h3F800000, 32'h30800000, 1'b0);
        cur_exp = mk(0, 0, 127, 27'h4000000, 27'h0000001, 0, 0, 0);
        send();
        load(32'h3F800000, 32'h3D800001, 1'b0);
        cur_exp = mk(0, 0, 127, 27'h4000000, 27'h0400001, 0, 0, 0);
        send();
        load(32'h00800000, 32'h00000001, 1'b0);
        cur_exp = mk(0, 0, 1, 27'h4000000, 27'h0000008, 0, 0, 0);
        send();
        load(32'h7F800000, 32'h7F800000, 1'b1);
        cur_exp = mk(0, 1, 255, 27'h4000000, 27'h4000000, 1, 0, 0);
        send();
        load(32'hFF800000, 32'h40A00000, 1'b0);
        cur_exp = mk(1, 1, 255, 27'h4000000, 27'h0000001, 0, 1, 0);
        send();
        load(32'h00000000, 32'h80000000, 1'b0);
        cur_exp = mk(0, 1, 1, 27'h0000000, 27'h0000000, 0, 0, 1);
        send();
        drain();

        // Backpressure: 5 stalled cycles while 4 pairs are offered
        out_ready = 1'b0;
        load(32'h40490FDB, 32'hC0000000, 1'b0);
        send();
        load(32'h3F000000, 32'h3F000001, 1'b1);
        send();
        load(32'h7FC00000, 32'h3F800000, 1'b0);
        in_valid = 1'b1;
        check("bp_in_ready_low", res_vec_t'(in_ready), '0);
        for (int c = 0; c < 3; c++) begin
            check("bp_valid_held", res_vec_t'(out_valid), 1);
            check("bp_data_held", obs(), sb[0]);
            step();
        end
        out_ready = 1'b1;
        send();
        load(32'h00400000, 32'h80200000, 1'b1);
        send();
        drain();
        check("bp_output_count", res_vec_t'(n_out), 12);

        // Stage-1 bubble while stage 2 is stalled still accepts
        out_ready = 1'b0;
        load(32'h41200000, 32'h3F800000, 1'b1);
        send();
        in_valid = 1'b0;
        step();
        check("bubble_in_ready", res_vec_t'(in_ready), 1);
        load(32'hC1200000, 32'h41200000, 1'b0);
        send();
        check("bubble_full", res_vec_t'(in_ready), '0);
        out_ready = 1'b1;
        drain();

        // Reset with two pairs in flight discards both
        load(32'h3F800000, 32'h40000000, 1'b0);
        send();
        load(32'h40400000, 32'h3F800000, 1'b1);
        send();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        check("rst_mid_out_valid", res_vec_t'(out_valid), '0);
        check("rst_mid_in_ready", res_vec_t'(in_ready), 1);
        check("rst_mid_outputs", obs(), '0);
        out_ready = 1'b1;
        repeat (6) step();
        check("rst_no_stale", res_vec_t'(out_valid), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
